// File: rtl/morse_tap_decoder.sv
// morse_tap_decoder: debounces a Morse key and turns press/release durations into dot, dash and gap strobes
module morse_tap_decoder #(
    parameter int DEBOUNCE_TICKS = 5,
    parameter int DOT_MAX_TICKS  = 200,
    parameter int CHAR_GAP_TICKS = 300,
    parameter int WORD_GAP_TICKS = 700,
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key,
    output logic [1:0] tap,
    output logic       tap_valid,
    output logic       char_end,
    output logic       word_end,
    output logic       key_db
);
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] DOT_MAX   = CNT_W'(DOT_MAX_TICKS);
    localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_GAP_TICKS - 1);

    state_t           state, state_n;
    logic [1:0]       sync;
    logic [CNT_W-1:0] db_cnt, dur, dur_n, dur_inc;
    logic             key_db_q, rise, fall;
    logic [1:0]       tap_n;
    logic             tap_valid_n, char_end_n, word_end_n;

    assign rise    = key_db & ~key_db_q;
    assign fall    = ~key_db & key_db_q;
    assign dur_inc = (tick && dur != '1) ? dur + 1'b1 : dur;

    // two-flop synchronizer on the raw key plus a delayed copy of key_db for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            key_db_q <= 1'b0;
        end else begin
            sync     <= {sync[0], key};
            key_db_q <= key_db;
        end
    end

    // debounce: key_db flips only after the synchronized key disagrees for DEBOUNCE_TICKS ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            key_db <= 1'b0;
        end else if (sync[1] == key_db) begin
            db_cnt <= '0;
        end else if (tick) begin
            if (db_cnt == DB_LAST) begin
                key_db <= ~key_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // decoder next-state: edges restart dur; gap thresholds fire on the tick that reaches them
    always_comb begin
        state_n     = state;
        dur_n       = dur;
        tap_n       = tap;
        tap_valid_n = 1'b0;
        char_end_n  = 1'b0;
        word_end_n  = 1'b0;
        case (state)
            IDLE: begin
                dur_n   = '0;
                state_n = rise ? PRESS : IDLE;
            end
            PRESS: begin
                if (fall) begin
                    tap_n       = (dur < DOT_MAX) ? 2'd2 : 2'd1;
                    tap_valid_n = 1'b1;
                    state_n     = GAP;
                    dur_n       = '0;
                end else begin
                    dur_n = dur_inc;
                end
            end
            GAP: begin
                if (rise) begin
                    state_n = PRESS;
                    dur_n   = '0;
                end else if (tick && dur == WORD_LAST) begin
                    word_end_n = 1'b1;
                    state_n    = IDLE;
                    dur_n      = '0;
                end else begin
                    dur_n = dur_inc;
                    if (tick && dur == CHAR_LAST) begin
                        tap_n       = 2'd0;
                        tap_valid_n = 1'b1;
                        char_end_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                dur_n   = '0;
            end
        endcase
    end

    // decoder state, duration counter and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dur       <= '0;
            tap       <= 2'd0;
            tap_valid <= 1'b0;
            char_end  <= 1'b0;
            word_end  <= 1'b0;
        end else begin
            state     <= state_n;
            dur       <= dur_n;
            tap       <= tap_n;
            tap_valid <= tap_valid_n;
            char_end  <= char_end_n;
            word_end  <= word_end_n;
        end
    end
endmodule
